// File: rtl/generic_pack.sv
// Shared types for the VFP configuration sequencer: command table entry layout and AXI response codes.
package generic_pack;

  typedef enum logic [1:0] {
    CFG_WRITE = 2'd0,
    CFG_POLL  = 2'd1,
    CFG_WAIT  = 2'd2,
    CFG_END   = 2'd3
  } cfg_op_e;

  typedef struct packed {
    cfg_op_e     op;
    logic [7:0]  addr;
    logic [31:0] data;
  } cfg_cmd_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/vfp_cfg_timer.sv
// Loadable 32-bit down-counter, saturating at zero, shared by WAIT delays and the POLL read budget.
// Load/decrement take effect on the next rising edge; no backpressure.
module vfp_cfg_timer (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        dec,
  output logic [31:0] count,
  output logic        zero
);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      count <= 32'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 32'd0)) begin
      count <= count - 32'd1;
    end
  end

  assign zero = (count == 32'd0);

endmodule

// File: rtl/vfp_config_sequencer.sv
// AXI4-Lite master that walks a WRITE/POLL/WAIT/END command table to program the VFP register map.
// Two cycles of fetch/decode per command; stalls on slave READY/VALID and never drops VALID before READY.
module vfp_config_sequencer
  import generic_pack::*;
#(
  parameter int          CMD_AW     = 6,
  parameter int unsigned POLL_LIMIT = 1024,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              start,
  output logic [CMD_AW-1:0] cmd_idx,
  input  logic [1:0]        cmd_op,
  input  logic [7:0]        cmd_addr,
  input  logic [31:0]       cmd_data,
  output logic [7:0]        AWADDR,
  output logic [2:0]        AWPROT,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [31:0]       WDATA,
  output logic [3:0]        WSTRB,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY,
  output logic [7:0]        ARADDR,
  output logic [2:0]        ARPROT,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [31:0]       RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RVALID,
  output logic              RREADY,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CMD_AW-1:0] err_idx
);

  localparam logic [3:0] S_IDLE         = 4'd0;
  localparam logic [3:0] S_FETCH        = 4'd1;
  localparam logic [3:0] S_DECODE       = 4'd2;
  localparam logic [3:0] S_WR_ADDR_DATA = 4'd3;
  localparam logic [3:0] S_WR_RESP      = 4'd4;
  localparam logic [3:0] S_RD_ADDR      = 4'd5;
  localparam logic [3:0] S_RD_DATA      = 4'd6;
  localparam logic [3:0] S_WAIT         = 4'd7;
  localparam logic [3:0] S_DONE         = 4'd8;
  localparam logic [3:0] S_ERR          = 4'd9;

  localparam logic [31:0]       POLL_LIMIT_W = 32'(POLL_LIMIT);
  localparam logic [CMD_AW-1:0] IDX_LAST     = {CMD_AW{1'b1}};
  localparam logic [CMD_AW-1:0] IDX_ONE      = {{(CMD_AW-1){1'b0}}, 1'b1};

  logic [3:0]        state, state_nxt;
  logic [CMD_AW-1:0] idx;
  logic [31:0]       poll_exp;
  logic              aw_vld, w_vld, ar_vld;
  logic [7:0]        aw_addr, ar_addr;
  logic [31:0]       w_dat;
  logic              error_q;
  logic [CMD_AW-1:0] err_idx_q;
  logic              auto_pending;
  logic              idle_like, start_go, advance;
  logic              tmr_load, tmr_dec, tmr_zero, tmr_expired;
  logic [31:0]       tmr_load_val, tmr_count;
  cfg_cmd_t          cmd_in;

  assign cmd_in    = '{op: cfg_op_e'(cmd_op), addr: cmd_addr, data: cmd_data};
  assign idle_like = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
  assign start_go  = idle_like && (start || auto_pending);
  // A count of 1 means this is the last allowed WAIT cycle / POLL read.
  assign tmr_expired = tmr_zero || (tmr_count == 32'd1);

  vfp_cfg_timer u_timer (
    .ACLK     (ACLK),
    .ARESETN  (ARESETN),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .count    (tmr_count),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_nxt    = state;
    advance      = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = cmd_in.data;
    tmr_dec      = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR: state_nxt = start_go ? S_FETCH : S_IDLE;
      S_FETCH:               state_nxt = S_DECODE;
      S_DECODE: begin
        case (cmd_in.op)
          CFG_WRITE: state_nxt = S_WR_ADDR_DATA;
          CFG_POLL: begin
            state_nxt    = S_RD_ADDR;
            tmr_load     = 1'b1;
            tmr_load_val = POLL_LIMIT_W;
          end
          CFG_WAIT: begin
            state_nxt = S_WAIT;
            tmr_load  = 1'b1;
          end
          default:   state_nxt = S_DONE;
        endcase
      end
      S_WR_ADDR_DATA: begin
        if ((!aw_vld || AWREADY) && (!w_vld || WREADY)) state_nxt = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (BVALID) begin
          if (BRESP == AXI_RESP_OKAY) advance = 1'b1;
          else                        state_nxt = S_ERR;
        end
      end
      S_RD_ADDR: begin
        if (ARREADY) state_nxt = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (RVALID) begin
          if (RRESP != AXI_RESP_OKAY) state_nxt = S_ERR;
          else if (RDATA == poll_exp) advance = 1'b1;
          else if (tmr_expired)       state_nxt = S_ERR;
          else begin
            tmr_dec   = 1'b1;
            state_nxt = S_RD_ADDR;
          end
        end
      end
      S_WAIT: begin
        if (tmr_expired) advance = 1'b1;
        else             tmr_dec = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
    // Running off the end of the table behaves like an END entry.
    if (advance) state_nxt = (idx == IDX_LAST) ? S_DONE : S_FETCH;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state        <= S_IDLE;
      idx          <= '0;
      poll_exp     <= 32'd0;
      aw_vld       <= 1'b0;
      w_vld        <= 1'b0;
      ar_vld       <= 1'b0;
      aw_addr      <= 8'd0;
      ar_addr      <= 8'd0;
      w_dat        <= 32'd0;
      error_q      <= 1'b0;
      err_idx_q    <= '0;
      auto_pending <= AUTO_START;
    end else begin
      state        <= state_nxt;
      auto_pending <= 1'b0;
      if (start_go) begin
        idx       <= '0;
        error_q   <= 1'b0;
        err_idx_q <= '0;
      end else if (advance) begin
        idx <= idx + IDX_ONE;
      end
      if (state == S_DECODE) begin
        poll_exp <= cmd_in.data;
        if (cmd_in.op == CFG_WRITE) begin
          aw_vld  <= 1'b1;
          w_vld   <= 1'b1;
          aw_addr <= cmd_in.addr;
          w_dat   <= cmd_in.data;
        end
        if (cmd_in.op == CFG_POLL) begin
          ar_vld  <= 1'b1;
          ar_addr <= cmd_in.addr;
        end
      end
      if (aw_vld && AWREADY) aw_vld <= 1'b0;
      if (w_vld && WREADY)   w_vld  <= 1'b0;
      if (ar_vld && ARREADY) ar_vld <= 1'b0;
      if ((state == S_RD_DATA) && (state_nxt == S_RD_ADDR)) ar_vld <= 1'b1;
      if (state_nxt == S_ERR) begin
        error_q   <= 1'b1;
        err_idx_q <= idx;
      end
    end
  end

  assign cmd_idx = idx;
  assign AWADDR  = aw_addr;
  assign AWPROT  = 3'b000;
  assign AWVALID = aw_vld;
  assign WDATA   = w_dat;
  assign WSTRB   = 4'hF;
  assign WVALID  = w_vld;
  assign BREADY  = (state == S_WR_RESP);
  assign ARADDR  = ar_addr;
  assign ARPROT  = 3'b000;
  assign ARVALID = ar_vld;
  assign RREADY  = (state == S_RD_DATA);
  assign busy    = !idle_like;
  assign done    = (state == S_DONE);
  assign error   = error_q;
  assign err_idx = err_idx_q;

endmodule

// File: tb/tb_vfp_config_sequencer.sv
// Directed bench for vfp_config_sequencer: table ROM, reactive AXI4-Lite slave, handshake monitor.
module tb_vfp_config_sequencer;
  import generic_pack::*;

  localparam int CMD_AW = 6;

  logic              ACLK = 1'b0;
  logic              ARESETN = 1'b1;
  logic              start = 1'b0;
  logic [CMD_AW-1:0] cmd_idx;
  logic [1:0]        cmd_op = 2'd3;
  logic [7:0]        cmd_addr = 8'd0;
  logic [31:0]       cmd_data = 32'd0;
  logic [7:0]        AWADDR, ARADDR;
  logic [2:0]        AWPROT, ARPROT;
  logic              AWVALID, WVALID, BREADY, ARVALID, RREADY;
  logic              AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0, ARREADY = 1'b0, RVALID = 1'b0;
  logic [31:0]       WDATA;
  logic [3:0]        WSTRB;
  logic [1:0]        BRESP = 2'b00, RRESP = 2'b00;
  logic [31:0]       RDATA = 32'd0;
  logic              busy, done, error;
  logic [CMD_AW-1:0] err_idx;

  vfp_config_sequencer #(.CMD_AW(CMD_AW), .POLL_LIMIT(8), .AUTO_START(1'b1)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .cmd_idx(cmd_idx),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .busy(busy), .done(done), .error(error), .err_idx(err_idx)
  );

  initial forever #5 ACLK = ~ACLK;

  cfg_cmd_t tbl [64];
  int vectors = 0, miscompares = 0;
  // Monitor-owned counters (cumulative; tests use deltas from snapshots).
  int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, done_cnt = 0, busy_cycles = 0;
  int awv_cycles = 0, wv_cycles = 0, viol = 0;
  logic [7:0]  aw_log [$];
  logic [31:0] w_log [$];
  logic [7:0]  ar_log [$];
  // Slave behaviour knobs, written only by the stimulus block.
  int aw_delay = 0, bresp_err_at = -1, rresp_err_at = -1, poll_hit = 0, rd_base = 0;
  int b_aw, b_w, b_b, b_ar, b_done, b_busy, b_awv, b_wv;

  // Command table ROM: data follows cmd_idx within the same cycle it changes.
  initial forever begin
    @(posedge ACLK); #1;
    cmd_op   = tbl[cmd_idx].op;
    cmd_addr = tbl[cmd_idx].addr;
    cmd_data = tbl[cmd_idx].data;
  end

  initial begin : slave
    int aw_cnt;
    aw_cnt = 0;
    forever begin
      @(posedge ACLK); #1;
      AWREADY = AWVALID && (aw_cnt >= aw_delay);
      if (AWVALID) aw_cnt++; else aw_cnt = 0;
      WREADY  = WVALID;
      BVALID  = BREADY;
      BRESP   = (aw_hs == bresp_err_at) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      ARREADY = ARVALID;
      RVALID  = RREADY;
      RRESP   = (ar_hs == rresp_err_at) ? AXI_RESP_DECERR : AXI_RESP_OKAY;
      RDATA   = ((ar_hs - rd_base) == poll_hit) ? 32'd1 : 32'd0;
    end
  end

  initial begin : monitor
    logic pv_aw, pv_w, pv_ar, ph_aw, ph_w, ph_ar;
    logic [7:0] pa_aw, pa_ar;
    logic [31:0] pd_w;
    {pv_aw, pv_w, pv_ar, ph_aw, ph_w, ph_ar} = '0;
    pa_aw = '0; pa_ar = '0; pd_w = '0;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        {pv_aw, pv_w, pv_ar} = '0;
      end else begin
        if (pv_aw && !ph_aw && (!AWVALID || AWADDR !== pa_aw)) viol++;
        if (pv_w  && !ph_w  && (!WVALID  || WDATA  !== pd_w))  viol++;
        if (pv_ar && !ph_ar && (!ARVALID || ARADDR !== pa_ar)) viol++;
        pv_aw = AWVALID; ph_aw = AWREADY; pa_aw = AWADDR;
        pv_w  = WVALID;  ph_w  = WREADY;  pd_w  = WDATA;
        pv_ar = ARVALID; ph_ar = ARREADY; pa_ar = ARADDR;
        if (AWVALID && AWREADY) begin aw_hs++; aw_log.push_back(AWADDR); end
        if (WVALID && WREADY)   begin w_hs++;  w_log.push_back(WDATA);   end
        if (BVALID && BREADY)   b_hs++;
        if (ARVALID && ARREADY) begin ar_hs++; ar_log.push_back(ARADDR); end
        if (done)    done_cnt++;
        if (busy)    busy_cycles++;
        if (AWVALID) awv_cycles++;
        if (WVALID)  wv_cycles++;
      end
    end
  end

  task automatic tick();
    @(negedge ACLK); #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input int i, input cfg_op_e op, input logic [7:0] a, input logic [31:0] d);
    tbl[i] = '{op: op, addr: a, data: d};
  endtask

  task automatic clear_tbl();
    for (int i = 0; i < 64; i++) set_cmd(i, CFG_END, 8'h00, 32'h0);
  endtask

  task automatic snap();
    b_aw = aw_hs; b_w = w_hs; b_b = b_hs; b_ar = ar_hs; b_done = done_cnt;
    b_busy = busy_cycles; b_awv = awv_cycles; b_wv = wv_cycles;
  endtask

  // Releasing reset launches the table through AUTO_START.
  task automatic do_reset();
    tick();
    ARESETN = 1'b0;
    start = 1'b0;
    repeat (2) tick();
    ARESETN = 1'b1;
    snap();
    rd_base = ar_hs;
  endtask

  task automatic wait_end(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done || error) begin ok = 1'b1; break; end
    end
  endtask

  initial begin : stim
    logic ok;
    int gap;
    clear_tbl();
    #1 ARESETN = 1'b0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done_err", {done, error}, 0);
    check("rst_idx", {cmd_idx, err_idx}, 0);
    check("rst_valid_ready", {AWVALID, WVALID, ARVALID, BREADY, RREADY}, 0);
    check("rst_addr_data", {AWADDR, ARADDR, WDATA[15:0]}, 0);
    check("rst_tied", {AWPROT, ARPROT, WSTRB}, 10'h00F);

    // T1: two writes then END; restart in the done cycle; start mid-run is ignored.
    set_cmd(0, CFG_WRITE, 8'h04, 32'h1);
    set_cmd(1, CFG_WRITE, 8'h08, 32'hFF);
    set_cmd(2, CFG_END, 8'h00, 32'h0);
    tick();
    ARESETN = 1'b1;
    snap();
    tick();
    check("t1_autostart_busy", busy, 1);
    wait_end(100, ok);
    check("t1_end_seen", ok, 1);
    check("t1_aw_count", aw_hs - b_aw, 2);
    check("t1_w_count", w_hs - b_w, 2);
    check("t1_b_count", b_hs - b_b, 2);
    check("t1_aw0", aw_log[b_aw], 8'h04);
    check("t1_w0", w_log[b_w], 32'h1);
    check("t1_aw1", aw_log[b_aw+1], 8'h08);
    check("t1_w1", w_log[b_w+1], 32'hFF);
    check("t1_done_once", done_cnt - b_done, 1);
    check("t1_no_err_idle", {error, busy}, 0);
    check("t1_no_reads", ar_hs - b_ar, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_restart_on_done", busy, 1);
    for (int i = 0; i < 50 && (aw_hs - b_aw) < 3; i++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_end(100, ok);
    check("t1_rerun_end", ok, 1);
    check("t1_rerun_aw_count", aw_hs - b_aw, 4);
    check("t1_rerun_aw2", aw_log[b_aw+2], 8'h04);
    check("t1_done_twice", done_cnt - b_done, 2);

    // T2: AWREADY three cycles late, WREADY immediate.
    clear_tbl();
    set_cmd(0, CFG_WRITE, 8'h20, 32'hA5);
    aw_delay = 3;
    do_reset();
    wait_end(100, ok);
    aw_delay = 0;
    check("t2_end_seen", ok, 1);
    check("t2_awvalid_cycles", awv_cycles - b_awv, 4);
    check("t2_wvalid_cycles", wv_cycles - b_wv, 1);
    check("t2_aw_addr", aw_log[b_aw], 8'h20);
    check("t2_single_b", b_hs - b_b, 1);

    // T3: POLL answered 0,0,1 then a write.
    clear_tbl();
    set_cmd(0, CFG_POLL, 8'h10, 32'h1);
    set_cmd(1, CFG_WRITE, 8'h30, 32'h7);
    poll_hit = 3;
    do_reset();
    wait_end(100, ok);
    check("t3_end_seen", ok, 1);
    check("t3_reads", ar_hs - b_ar, 3);
    check("t3_read_addr", ar_log[b_ar+2], 8'h10);
    check("t3_next_write", {aw_log[b_aw], w_log[b_w][7:0]}, 16'h3007);
    check("t3_done_no_err", {done_cnt - b_done == 1, error}, 2'b10);

    // T4: POLL never matches; budget of 8 reads.
    clear_tbl();
    set_cmd(0, CFG_WRITE, 8'h04, 32'h1);
    set_cmd(1, CFG_POLL, 8'h14, 32'hDEAD);
    set_cmd(2, CFG_WRITE, 8'h08, 32'h2);
    poll_hit = 0;
    do_reset();
    wait_end(200, ok);
    check("t4_end_seen", ok, 1);
    check("t4_err_busy", {error, busy}, 2'b10);
    check("t4_err_idx", err_idx, 1);
    check("t4_reads", ar_hs - b_ar, 8);
    repeat (10) tick();
    check("t4_quiet_reads", ar_hs - b_ar, 8);
    check("t4_quiet_writes", aw_hs - b_aw, 1);
    check("t4_sticky_no_done", {error, done_cnt - b_done == 0}, 2'b11);

    // T5: SLVERR on the second write, then a clean rerun.
    clear_tbl();
    set_cmd(0, CFG_WRITE, 8'h04, 32'h1);
    set_cmd(1, CFG_WRITE, 8'h08, 32'h2);
    set_cmd(2, CFG_WRITE, 8'h0C, 32'h3);
    do_reset();
    bresp_err_at = b_aw + 2;
    wait_end(100, ok);
    check("t5_end_seen", ok, 1);
    check("t5_error", error, 1);
    check("t5_err_idx", err_idx, 1);
    repeat (5) tick();
    check("t5_no_third_write", aw_hs - b_aw, 2);
    bresp_err_at = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_start_clears", {error, busy}, 2'b01);
    wait_end(100, ok);
    check("t5_rerun_end", ok, 1);
    check("t5_rerun_writes", aw_hs - b_aw, 5);
    check("t5_rerun_third", aw_log[b_aw+4], 8'h0C);
    check("t5_rerun_done", {done_cnt - b_done == 1, error}, 2'b10);

    // T7: DECERR on a POLL read.
    clear_tbl();
    set_cmd(0, CFG_POLL, 8'h18, 32'h1);
    do_reset();
    rresp_err_at = b_ar + 2;
    wait_end(100, ok);
    rresp_err_at = -1;
    check("t7_end_seen", ok, 1);
    check("t7_err", {error, busy}, 2'b10);
    check("t7_err_idx", err_idx, 0);
    check("t7_reads", ar_hs - b_ar, 2);

    // T6: WAIT 5 = FETCH+DECODE, 5 WAIT cycles, FETCH+DECODE of the write -> 9 busy cycles first.
    clear_tbl();
    set_cmd(0, CFG_WAIT, 8'h00, 32'd5);
    set_cmd(1, CFG_WRITE, 8'h40, 32'h55);
    do_reset();
    gap = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (AWVALID) break;
      if (busy) gap++;
    end
    check("t6_wait_gap", gap, 9);
    wait_end(100, ok);
    check("t6_wait_done", done_cnt - b_done, 1);

    // Whole table of WAIT 0: three cycles each, wrap past index 63 ends the run.
    for (int i = 0; i < 64; i++) set_cmd(i, CFG_WAIT, 8'h00, 32'd0);
    do_reset();
    wait_end(400, ok);
    check("t6_wrap_end", ok, 1);
    check("t6_wrap_busy_cycles", busy_cycles - b_busy, 192);
    check("t6_wrap_done_no_bus", {done_cnt - b_done == 1, aw_hs == b_aw, ar_hs == b_ar}, 3'b111);

    // Asynchronous reset in the middle of a WAIT.
    clear_tbl();
    set_cmd(0, CFG_WRITE, 8'h04, 32'h1);
    set_cmd(1, CFG_WAIT, 8'h00, 32'd20);
    do_reset();
    for (int i = 0; i < 60 && (b_hs - b_b) < 1; i++) tick();
    repeat (4) tick();
    check("t6_pre_reset", {busy, cmd_idx}, {1'b1, 6'd1});
    ARESETN = 1'b0;
    #1;
    check("t6_arst_busy_idx", {busy, cmd_idx}, 0);
    check("t6_arst_bus", {AWADDR, WDATA[7:0]}, 0);
    check("t6_arst_flags", {done, error, AWVALID, WVALID, ARVALID, BREADY, RREADY}, 0);
    tick();
    ARESETN = 1'b1;
    tick();

    check("axi_stability", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
